// File: rtl/led_pwm_fade.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_fade
// Purpose  : Per-channel fade-up/fade-down brightness with a shared PWM
//            counter, giving running LEDs a comet-tail effect.
// Revision : 1.0
// ============================================================================
module led_pwm_fade #(
  parameter int CH        = 3,
  parameter int PWM_BITS  = 8,
  parameter int STEP_DIV  = 50_000,
  parameter int FADE_STEP = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic [CH-1:0]          LED_IN,
  output logic [CH-1:0]          LED_PWM,
  output logic [CH*PWM_BITS-1:0] LEVEL_OUT,
  output logic                   BUSY
);

  localparam int                  c_pre_w    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [c_pre_w-1:0]  c_pre_last = c_pre_w'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] c_max      = '1;
  localparam logic [PWM_BITS:0]   c_max_ext  = {1'b0, c_max};
  localparam logic [PWM_BITS:0]   c_step     = (PWM_BITS + 1)'(FADE_STEP);

  logic [CH-1:0]                led_q;
  logic [c_pre_w-1:0]           pre_q, pre_d;
  logic [PWM_BITS-1:0]          pwm_q, pwm_d;
  logic [CH-1:0][PWM_BITS-1:0]  level_q, level_d;
  logic [CH-1:0][PWM_BITS-1:0]  act_q, act_d;
  logic [CH-1:0]                out_q, out_d;

  logic                         w_tick;
  logic                         w_wrap;
  logic [CH-1:0][PWM_BITS-1:0]  w_target;
  logic [CH-1:0]                w_diff;

  always_comb begin
    logic [PWM_BITS:0] up;
    up     = '0;
    w_tick = (pre_q == c_pre_last);
    w_wrap = (pwm_q == c_max);
    pre_d  = w_tick ? '0 : pre_q + 1'b1;
    pwm_d  = pwm_q + 1'b1;
    for (int i = 0; i < CH; i++) begin
      w_target[i] = led_q[i] ? c_max : '0;
      w_diff[i]   = (level_q[i] != w_target[i]);
      level_d[i]  = level_q[i];
      // Arithmetic is done one bit wider so saturation at MAX cannot wrap.
      up = {1'b0, level_q[i]} + c_step;
      if (w_tick) begin
        if (level_q[i] < w_target[i]) begin
          level_d[i] = (up > c_max_ext) ? c_max : up[PWM_BITS-1:0];
        end else if (level_q[i] > w_target[i]) begin
          level_d[i] = ({1'b0, level_q[i]} >= c_step) ?
                       (level_q[i] - c_step[PWM_BITS-1:0]) : '0;
        end
      end
      act_d[i] = w_wrap ? level_q[i] : act_q[i];
      out_d[i] = (act_q[i] == c_max) || (act_q[i] > pwm_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_q   <= '0;
      pre_q   <= '0;
      pwm_q   <= '0;
      level_q <= '0;
      act_q   <= '0;
      out_q   <= '0;
    end else begin
      led_q <= LED_IN;
      if (!EN) begin
        pre_q   <= '0;
        pwm_q   <= '0;
        level_q <= '0;
        act_q   <= '0;
        out_q   <= '0;
      end else begin
        pre_q   <= pre_d;
        pwm_q   <= pwm_d;
        level_q <= level_d;
        act_q   <= act_d;
        out_q   <= out_d;
      end
    end
  end

  assign LED_PWM   = out_q;
  assign LEVEL_OUT = level_q;
  assign BUSY      = EN & (|w_diff);

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fade.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_led_pwm_fade
// Purpose  : Self-checking bench for led_pwm_fade against a time-count model.
// Revision : 1.0
// ============================================================================
module tb_led_pwm_fade;

  localparam int CH   = 3;
  localparam int PB   = 8;
  localparam int SD   = 4;
  localparam int FS   = 64;
  localparam int MAXV = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [CH-1:0]     led_in;
  logic [CH-1:0]     led_pwm;
  logic [CH*PB-1:0]  level_out;
  logic              busy;

  always #5 clk = ~clk;

  led_pwm_fade #(.CH(CH), .PWM_BITS(PB), .STEP_DIV(SD), .FADE_STEP(FS)) dut (
    .CLK(clk), .RST(rst), .EN(en), .LED_IN(led_in),
    .LED_PWM(led_pwm), .LEVEL_OUT(level_out), .BUSY(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: time since enable drives both prescaler and PWM phase.
  int            m_lvl [CH];
  int            m_act [CH];
  int            m_out [CH];
  int            m_t;
  logic [CH-1:0] m_led;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int fade(input int l, input int tgt);
    if (l < tgt) return (l + FS > MAXV) ? MAXV : l + FS;
    if (l > tgt) return (l - FS < 0) ? 0 : l - FS;
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_lvl[i] = 0; m_act[i] = 0; m_out[i] = 0;
    end
    m_t   = 0;
    m_led = '0;
  endtask

  task automatic model_clock(input logic e, input logic [CH-1:0] li);
    int pwm;
    bit tick;
    pwm  = m_t % (MAXV + 1);
    tick = ((m_t % SD) == SD - 1);
    for (int i = 0; i < CH; i++) begin
      if (e) begin
        m_out[i] = (m_act[i] == MAXV || m_act[i] > pwm) ? 1 : 0;
        if (pwm == MAXV) m_act[i] = m_lvl[i];
        if (tick) m_lvl[i] = fade(m_lvl[i], m_led[i] ? MAXV : 0);
      end else begin
        m_out[i] = 0; m_act[i] = 0; m_lvl[i] = 0;
      end
    end
    m_t   = e ? m_t + 1 : 0;
    m_led = li;
  endtask

  task automatic check_all(input string tag);
    logic [CH*PB-1:0] el;
    logic [CH-1:0]    ep;
    logic             eb;
    eb = 1'b0;
    for (int i = 0; i < CH; i++) begin
      el[i*PB +: PB] = PB'(m_lvl[i]);
      ep[i]          = m_out[i][0];
      if (m_lvl[i] != (m_led[i] ? MAXV : 0)) eb = 1'b1;
    end
    eb = eb & en & ~rst;
    check({tag, ".pwm"},   32'(led_pwm),   32'(ep));
    check({tag, ".level"}, 32'(level_out), 32'(el));
    check({tag, ".busy"},  32'(busy),      32'(eb));
  endtask

  task automatic cyc(input logic e, input logic [CH-1:0] li, input string tag);
    en     = e;
    led_in = li;
    @(posedge clk);
    if (rst) model_reset();
    else     model_clock(e, li);
    #1 check_all(tag);
  endtask

  task automatic collect(input logic [CH-1:0] li, input int n, input string tag,
                         output int q[$]);
    q = {};
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, li, tag);
      if (q.size() == 0 || q[$] != int'(level_out[PB-1:0])) q.push_back(int'(level_out[PB-1:0]));
    end
  endtask

  initial begin
    int seq[$];
    int exp_up[5];
    int exp_dn[5];
    int hi0, hi1;
    exp_up = '{0, 64, 128, 192, 255};
    exp_dn = '{255, 191, 127, 63, 0};

    rst = 1'b1; en = 1'b1; led_in = 3'b111;
    model_reset();
    cyc(1'b1, 3'b111, "reset");
    cyc(1'b1, 3'b111, "reset");
    rst = 1'b0;
    cyc(1'b1, 3'b111, "rel");
    cyc(1'b1, 3'b111, "rel");
    check("busy_after_release", 32'(busy), 32'd1);

    rst = 1'b1;
    cyc(1'b1, 3'b000, "rst2");
    rst = 1'b0;

    collect(3'b001, 24, "up", seq);
    check("up_len", 32'(seq.size()), 32'd5);
    for (int k = 0; k < 5 && k < seq.size(); k++) check("up_seq", 32'(seq[k]), 32'(exp_up[k]));
    check("up_busy_done", 32'(busy), 32'd0);
    check("up_other_ch", 32'(level_out[CH*PB-1:PB]), 32'd0);

    for (int k = 0; k < 300; k++) cyc(1'b1, 3'b001, "hold");
    hi0 = 0; hi1 = 0;
    for (int k = 0; k < 256; k++) begin
      cyc(1'b1, 3'b001, "duty_full");
      hi0 += int'(led_pwm[0]);
      hi1 += int'(led_pwm[1]);
    end
    check("duty_255", 32'(hi0), 32'd256);
    check("duty_0",   32'(hi1), 32'd0);

    collect(3'b000, 24, "down", seq);
    check("down_len", 32'(seq.size()), 32'd5);
    for (int k = 0; k < 5 && k < seq.size(); k++) check("down_seq", 32'(seq[k]), 32'(exp_dn[k]));
    for (int k = 0; k < 300; k++) cyc(1'b1, 3'b000, "low_hold");
    hi0 = 0;
    for (int k = 0; k < 256; k++) begin
      cyc(1'b1, 3'b000, "duty_off");
      hi0 += int'(led_pwm[0]);
    end
    check("duty_off_ch0", 32'(hi0), 32'd0);

    // Drop EN mid-fade at level 128, then re-enable.
    for (int k = 0; k < 64 && level_out[PB-1:0] != 8'd128; k++) cyc(1'b1, 3'b001, "to128");
    check("reach128", 32'(level_out[PB-1:0]), 32'd128);
    cyc(1'b0, 3'b001, "en_off");
    check("en_off_pwm",   32'(led_pwm),   32'd0);
    check("en_off_level", 32'(level_out), 32'd0);
    check("en_off_busy",  32'(busy),      32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 3'b001, "en_off_hold");
    for (int k = 0; k < 3; k++) cyc(1'b1, 3'b001, "en_on");
    check("restart_zero", 32'(level_out[PB-1:0]), 32'd0);
    cyc(1'b1, 3'b001, "en_on");
    check("restart_first_step", 32'(level_out[PB-1:0]), 32'd64);

    // Async reset with LED lit, checked before the next clock edge.
    for (int k = 0; k < 600; k++) cyc(1'b1, 3'b001, "pre_arst");
    check("pre_arst_lit", 32'(led_pwm[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_pwm",   32'(led_pwm),   32'd0);
    check("arst_level", 32'(level_out), 32'd0);
    model_reset();
    cyc(1'b1, 3'b001, "arst_hold");
    rst = 1'b0;

    // Randomized phase.
    begin
      logic          e;
      logic [CH-1:0] li;
      e = 1'b1; li = 3'b000;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 31) == 0) li = CH'($urandom);
        e = ($urandom_range(0, 99) != 0);
        if ($urandom_range(0, 499) == 0) begin
          #2 rst = 1'b1;
          #1 check("rand_arst_pwm", 32'(led_pwm), 32'd0);
          model_reset();
          cyc(e, li, "rand_rst");
          rst = 1'b0;
        end else begin
          cyc(e, li, "rand");
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
